// File: rtl/dmem_lsu_if.sv
// CPU-side request/response and byte-wide data-memory signals of the load/store unit.
// The slave modport is the LSU; the master modport is its environment (CPU + memory).
interface dmem_lsu_if #(
   parameter int unsigned ADDR_W = 15
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: splits byte/half/word requests into little-endian byte accesses
// on an 8-bit memory with 1-cycle read latency, and returns one response per request.
module dmem_lsu #(
   parameter int unsigned ADDR_W      = 15,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   dmem_lsu_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_STORE, S_LOAD, S_DRAIN, S_RESP} state_t;

   state_t            r_state, w_nxt_state;
   logic [1:0]        r_cnt, w_nxt_cnt;
   logic [1:0]        r_size, w_nxt_size;
   logic              r_uns, w_nxt_uns;
   logic [31:0]       r_wdata, w_nxt_wdata;
   logic [31:0]       r_rbuf, w_nxt_rbuf;
   logic              r_req_ready, w_nxt_req_ready;
   logic              r_resp_valid, w_nxt_resp_valid;
   logic              r_resp_err, w_nxt_resp_err;
   logic [31:0]       r_resp_rdata, w_nxt_resp_rdata;
   logic [ADDR_W-1:0] r_mem_addr, w_nxt_mem_addr;
   logic              r_mem_re, w_nxt_mem_re;
   logic              r_mem_we, w_nxt_mem_we;
   logic [7:0]        r_mem_wdata, w_nxt_mem_wdata;

   logic              w_req_err;
   logic              w_last;
   logic [1:0]        w_cnt_inc;
   logic [1:0]        w_cnt_dec;

   function automatic logic [1:0] last_idx(input logic [1:0] size);
      case (size)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                          input logic uns);
      case (size)
         2'b00:   return uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   assign w_req_err = (bus.req_size == 2'b11) ||
                      (ALIGN_CHECK && (((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))));
   assign w_last    = (r_cnt == last_idx(r_size));
   assign w_cnt_inc = r_cnt + 2'd1;
   assign w_cnt_dec = r_cnt - 2'd1;

   // State and all outputs are registered; memory outputs never see req_* combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_size       <= '0;
         r_uns        <= 1'b0;
         r_wdata      <= '0;
         r_rbuf       <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         r_mem_addr   <= '0;
         r_mem_re     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_cnt        <= w_nxt_cnt;
         r_size       <= w_nxt_size;
         r_uns        <= w_nxt_uns;
         r_wdata      <= w_nxt_wdata;
         r_rbuf       <= w_nxt_rbuf;
         r_req_ready  <= w_nxt_req_ready;
         r_resp_valid <= w_nxt_resp_valid;
         r_resp_err   <= w_nxt_resp_err;
         r_resp_rdata <= w_nxt_resp_rdata;
         r_mem_addr   <= w_nxt_mem_addr;
         r_mem_re     <= w_nxt_mem_re;
         r_mem_we     <= w_nxt_mem_we;
         r_mem_wdata  <= w_nxt_mem_wdata;
      end
   end

   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_cnt        = r_cnt;
      w_nxt_size       = r_size;
      w_nxt_uns        = r_uns;
      w_nxt_wdata      = r_wdata;
      w_nxt_rbuf       = r_rbuf;
      w_nxt_req_ready  = 1'b0;
      w_nxt_resp_valid = 1'b0;
      w_nxt_resp_err   = 1'b0;
      w_nxt_resp_rdata = '0;
      w_nxt_mem_addr   = r_mem_addr;
      w_nxt_mem_re     = 1'b0;
      w_nxt_mem_we     = 1'b0;
      w_nxt_mem_wdata  = r_mem_wdata;

      case (r_state)
         S_IDLE: begin
            w_nxt_req_ready = 1'b1;
            if (bus.req_valid) begin
               w_nxt_req_ready = 1'b0;
               w_nxt_size      = bus.req_size;
               w_nxt_uns       = bus.req_unsigned;
               w_nxt_wdata     = bus.req_wdata;
               w_nxt_cnt       = 2'd0;
               if (w_req_err) begin
                  w_nxt_state      = S_RESP;
                  w_nxt_resp_valid = 1'b1;
                  w_nxt_resp_err   = 1'b1;
               end else if (bus.req_we) begin
                  w_nxt_state     = S_STORE;
                  w_nxt_mem_we    = 1'b1;
                  w_nxt_mem_addr  = bus.req_addr;
                  w_nxt_mem_wdata = bus.req_wdata[7:0];
               end else begin
                  w_nxt_state    = S_LOAD;
                  w_nxt_mem_re   = 1'b1;
                  w_nxt_mem_addr = bus.req_addr;
                  w_nxt_rbuf     = '0;
               end
            end
         end
         S_STORE: begin
            if (w_last) begin
               w_nxt_state      = S_RESP;
               w_nxt_resp_valid = 1'b1;
            end else begin
               w_nxt_cnt       = w_cnt_inc;
               w_nxt_mem_we    = 1'b1;
               w_nxt_mem_addr  = r_mem_addr + ADDR_W'(1);
               w_nxt_mem_wdata = r_wdata[{w_cnt_inc, 3'b000} +: 8];
            end
         end
         S_LOAD: begin
            // Read data lags the address by one cycle, so lane k lands while byte k+1 is addressed.
            if (r_cnt != 2'd0) w_nxt_rbuf[{w_cnt_dec, 3'b000} +: 8] = bus.mem_rdata;
            if (w_last) begin
               w_nxt_state = S_DRAIN;
            end else begin
               w_nxt_cnt      = w_cnt_inc;
               w_nxt_mem_re   = 1'b1;
               w_nxt_mem_addr = r_mem_addr + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            w_nxt_rbuf[{r_cnt, 3'b000} +: 8] = bus.mem_rdata;
            w_nxt_state      = S_RESP;
            w_nxt_resp_valid = 1'b1;
            w_nxt_resp_rdata = extend(w_nxt_rbuf, r_size, r_uns);
         end
         S_RESP: begin
            w_nxt_state     = S_IDLE;
            w_nxt_req_ready = 1'b1;
         end
         default: begin
            w_nxt_state     = S_IDLE;
            w_nxt_req_ready = 1'b1;
         end
      endcase
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_re     = r_mem_re;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: two DUTs (aligned-checking and wrapping) share one
// byte memory model; a select picks which one the driver and monitor talk to.
module tb_dmem_lsu;
   localparam int unsigned AW = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_lsu_if #(.ADDR_W(AW)) if0 ();
   dmem_lsu_if #(.ADDR_W(AW)) if1 ();

   dmem_lsu #(.ADDR_W(AW), .ALIGN_CHECK(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   dmem_lsu #(.ADDR_W(AW), .ALIGN_CHECK(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   logic          sel;
   logic          d_valid, d_we, d_uns;
   logic [1:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [7:0]    mem_q;

   assign if0.req_valid    = d_valid && !sel;
   assign if1.req_valid    = d_valid && sel;
   assign if0.req_we       = d_we;
   assign if1.req_we       = d_we;
   assign if0.req_size     = d_size;
   assign if1.req_size     = d_size;
   assign if0.req_unsigned = d_uns;
   assign if1.req_unsigned = d_uns;
   assign if0.req_addr     = d_addr;
   assign if1.req_addr     = d_addr;
   assign if0.req_wdata    = d_wdata;
   assign if1.req_wdata    = d_wdata;
   assign if0.mem_rdata    = mem_q;
   assign if1.mem_rdata    = mem_q;

   logic          m_ready, m_rv, m_err, m_re, m_we;
   logic [31:0]   m_rdata;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_wdata;
   assign m_ready = sel ? if1.req_ready  : if0.req_ready;
   assign m_rv    = sel ? if1.resp_valid : if0.resp_valid;
   assign m_err   = sel ? if1.resp_err   : if0.resp_err;
   assign m_rdata = sel ? if1.resp_rdata : if0.resp_rdata;
   assign m_re    = sel ? if1.mem_re     : if0.mem_re;
   assign m_we    = sel ? if1.mem_we     : if0.mem_we;
   assign m_addr  = sel ? if1.mem_addr   : if0.mem_addr;
   assign m_wdata = sel ? if1.mem_wdata  : if0.mem_wdata;

   // Byte memory with registered read
   logic [7:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (m_re) mem_q <= mem[m_addr];
      if (m_we) mem[m_addr] <= m_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int cyc; logic err; logic [31:0] rdata;} resp_t;
   typedef struct {int cyc; logic [AW-1:0] addr; logic [7:0] data;} acc_t;
   resp_t rq[$];
   acc_t  wq[$];
   acc_t  lq[$];
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected responses/accesses whenever the DUT presents one
   always @(negedge clk) begin
      resp_t e;
      acc_t  a;
      if (m_re || m_we) chk("re_we_exclusive", 32'(m_re & m_we), 32'd0);
      if (m_rv) begin
         if (rq.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
         else begin
            e = rq.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            chk("resp_err", 32'(m_err), 32'(e.err));
            chk("resp_rdata", m_rdata, e.rdata);
         end
      end
      if (m_we) begin
         if (wq.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
         else begin
            a = wq.pop_front();
            chk("write_cycle", 32'(cyc), 32'(a.cyc));
            chk("write_addr", 32'(m_addr), 32'(a.addr));
            chk("write_data", 32'(m_wdata), 32'(a.data));
         end
      end
      if (m_re) begin
         if (lq.size() == 0) chk("read_unexpected", 32'd1, 32'd0);
         else begin
            a = lq.pop_front();
            chk("read_cycle", 32'(cyc), 32'(a.cyc));
            chk("read_addr", 32'(m_addr), 32'(a.addr));
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input bit hold, input bit abort);
      int n, a0, bud;
      acc_t  acc;
      resp_t rsp;
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      @(negedge clk);
      d_valid = 1'b1; d_we = we; d_size = size; d_uns = uns; d_addr = addr; d_wdata = wdata;
      bud = 0;
      while (!m_ready && bud < 50) begin
         @(negedge clk);
         bud++;
      end
      if (!m_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         d_valid = 1'b0;
         return;
      end
      a0 = cyc + 1;
      if (!exp_err) begin
         for (int k = 0; k < n; k++) begin
            if (!(abort && k >= 2)) begin
               acc.cyc  = a0 + k;
               acc.addr = addr + AW'(k);
               acc.data = wdata[8*k +: 8];
               if (we) wq.push_back(acc);
               else    lq.push_back(acc);
            end
         end
      end
      if (!abort) begin
         rsp.cyc   = exp_err ? a0 : (we ? a0 + n : a0 + n + 1);
         rsp.err   = exp_err;
         rsp.rdata = exp_rdata;
         rq.push_back(rsp);
      end
      @(posedge clk);
      if (!hold) begin
         @(negedge clk);
         d_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int bud = 0;
      while ((rq.size() != 0 || wq.size() != 0 || lq.size() != 0) && bud < 100) begin
         @(negedge clk);
         bud++;
      end
      if (rq.size() != 0 || wq.size() != 0 || lq.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(m_ready), 32'd1);
      chk({tag, "_resp_valid"}, 32'(m_rv), 32'd0);
      chk({tag, "_resp_err"}, 32'(m_err), 32'd0);
      chk({tag, "_resp_rdata"}, m_rdata, 32'd0);
      chk({tag, "_mem_re"}, 32'(m_re), 32'd0);
      chk({tag, "_mem_we"}, 32'(m_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(m_addr), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(m_wdata), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0; d_valid = 1'b0; d_we = 1'b0; d_size = 2'b00; d_uns = 1'b0;
      d_addr = '0; d_wdata = '0; mem_q = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Word store, then loads of every size and extension
      issue(1'b1, 2'b10, 1'b0, 15'h0010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 15'h0010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      issue(1'b0, 2'b00, 1'b0, 15'h0013, 32'h0, 1'b0, 32'hFFFFFFDE, 1'b0, 1'b0);
      issue(1'b0, 2'b00, 1'b1, 15'h0013, 32'h0, 1'b0, 32'h000000DE, 1'b0, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 15'h0012, 32'h0, 1'b0, 32'hFFFFDEAD, 1'b0, 1'b0);
      issue(1'b0, 2'b01, 1'b1, 15'h0010, 32'h0, 1'b0, 32'h0000BEEF, 1'b0, 1'b0);
      issue(1'b1, 2'b01, 1'b0, 15'h0030, 32'h0000CAFE, 1'b0, 32'h0, 1'b0, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 15'h0030, 32'h0, 1'b0, 32'hFFFFCAFE, 1'b0, 1'b0);
      issue(1'b1, 2'b00, 1'b0, 15'h0040, 32'h1234567F, 1'b0, 32'h0, 1'b0, 1'b0);
      issue(1'b0, 2'b00, 1'b0, 15'h0040, 32'h0, 1'b0, 32'h0000007F, 1'b0, 1'b0);
      issue(1'b0, 2'b10, 1'b1, 15'h0040, 32'h0, 1'b0, 32'h0000007F, 1'b0, 1'b0);

      // Error responses: no memory traffic, response in cycle 1
      issue(1'b0, 2'b10, 1'b0, 15'h0011, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      issue(1'b0, 2'b11, 1'b0, 15'h0000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      issue(1'b1, 2'b01, 1'b0, 15'h0031, 32'h0000BBAA, 1'b1, 32'h0, 1'b0, 1'b0);
      wait_idle();
      chk("misaligned_store_untouched", 32'(mem[15'h0031]), 32'h000000CA);

      // Unchecked alignment: address wraps at the top of memory
      sel = 1'b1;
      issue(1'b1, 2'b10, 1'b0, 15'h7FFE, 32'h11223344, 1'b0, 32'h0, 1'b0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 15'h7FFE, 32'h0, 1'b0, 32'h11223344, 1'b0, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 15'h0011, 32'h0, 1'b0, 32'hFFFFADBE, 1'b0, 1'b0);
      issue(1'b0, 2'b11, 1'b0, 15'h0000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      wait_idle();
      sel = 1'b0;

      // Reset in cycle 2 of a word store aborts it after two bytes
      issue(1'b1, 2'b10, 1'b0, 15'h0020, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("abort");
      chk("abort_byte20", 32'(mem[15'h0020]), 32'h000000EF);
      chk("abort_byte21", 32'(mem[15'h0021]), 32'h000000BE);
      chk("abort_byte22", 32'(mem[15'h0022]), 32'h00000000);

      // Valid held high: back-to-back requests, one response each
      issue(1'b0, 2'b00, 1'b1, 15'h0021, 32'h0, 1'b0, 32'h000000BE, 1'b1, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 15'h0020, 32'h0, 1'b0, 32'hFFFFBEEF, 1'b1, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 15'h0020, 32'h0, 1'b0, 32'h0000BEEF, 1'b0, 1'b0);
      wait_idle();

      chk("resp_queue_empty", 32'(rq.size()), 32'd0);
      chk("write_queue_empty", 32'(wq.size()), 32'd0);
      chk("read_queue_empty", 32'(lq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
